// File: rtl/sprite_pkg.sv
// Shared constants for the sprite RAM arbiter: memory map, sprite bases,
// requester indices and the round-robin index helper.
package sprite_pkg;

   localparam int MEM_DEPTH   = 1707;
   localparam int MEM_LAST    = 1706;
   localparam int BLANK_ADDR  = 1706;
   localparam int SKY_ADDR    = 1704;
   localparam int GROUND_ADDR = 1705;

   localparam int CANNONBALL_BASE  = 0;
   localparam int CANNONBALL_SIZE  = 204;
   localparam int DEMO_RED_R_BASE  = 204;
   localparam int DEMO_RED_L_BASE  = 579;
   localparam int DEMO_BLUE_R_BASE = 954;
   localparam int DEMO_BLUE_L_BASE = 1329;
   localparam int DEMO_SIZE        = 375;

   typedef enum logic [1:0] {
      REQ_VIDEO  = 2'd0,
      REQ_GAME_A = 2'd1,
      REQ_GAME_B = 2'd2
   } req_idx_e;

   // k-th candidate after the pointer, walking only the game clients 1..n-1
   function automatic int rr_index(input int ptr, input int k, input int n);
      int p;
      p = ((ptr < 1) || (ptr >= n)) ? 1 : ptr;
      return 1 + ((p - 1 + k) % (n - 1));
   endfunction

endpackage

// File: rtl/sprite_rr_picker.sv
// Combinational selector over the game-client requests (index 0 is ignored),
// searching upward from ptr with wrap; ptr tied to 1 gives fixed priority.
module sprite_rr_picker
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   // first requesting client found from the pointer position wins
   always_comb begin
      gnt = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ - 1; k++) begin
         if ((gnt == {NUM_REQ{1'b0}}) && req[rr_index(int'(ptr), k, NUM_REQ)]) begin
            gnt[rr_index(int'(ptr), k, NUM_REQ)] = 1'b1;
         end else begin
            gnt = gnt;
         end
      end
   end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM read arbiter: video fetch has absolute priority, game clients share
// the rest. Define SPRITE_ARB_RR_EN for round-robin among clients (else fixed).
module sprite_ram_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      oob_err,
   output logic [NUM_REQ-1:0]        starve,
   input  logic                      wr_req,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [ADDR_W-1:0]         ram_read_address,
   output logic [ADDR_W-1:0]         ram_write_address,
   output logic [DATA_W-1:0]         ram_data_in,
   output logic                      ram_we,
   input  logic [DATA_W-1:0]         ram_data_out
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_LAST);
   localparam logic [ADDR_W-1:0] BLANK_A = ADDR_W'(BLANK_ADDR);
   localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [PTR_W-1:0]   ptr_s;
   logic [NUM_REQ-1:0] pick_gnt_s;
   logic [NUM_REQ-1:0] gnt_s;
   logic [ADDR_W-1:0]  gaddr_s;
   logic               any_gnt_s;
   logic               oob_s;
   logic               ram_we_s;
   logic               bypass_hit_s;
   logic [DATA_W-1:0]  rdata_s;

   logic [NUM_REQ-1:0] rvalid_r;
   logic               oob_r;
   logic               bypass_r;
   logic [DATA_W-1:0]  bypass_data_r;
   logic [NUM_REQ-1:0] starve_r;
   logic [CNT_W-1:0]   wait_r     [NUM_REQ];
   logic [CNT_W-1:0]   wait_nxt_s [NUM_REQ];

`ifdef SPRITE_ARB_RR_EN
   logic [PTR_W-1:0] ptr_r;
   logic [PTR_W-1:0] ptr_nxt_s;
   logic [PTR_W-1:0] win_s;

   // pointer moves one past the client that just won, wrapping back to 1
   always_comb begin
      win_s = {PTR_W{1'b0}};
      for (int i = 1; i < NUM_REQ; i++) begin
         win_s = win_s | (PTR_W'(i) & {PTR_W{gnt_s[i]}});
      end
      if (any_gnt_s && !gnt_s[REQ_VIDEO]) begin
         ptr_nxt_s = (win_s == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : (win_s + PTR_W'(1));
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // round-robin pointer register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= PTR_W'(1);
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   assign ptr_s = ptr_r;
`else
   assign ptr_s = PTR_W'(1);
`endif

   sprite_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req (req),
      .ptr (ptr_s),
      .gnt (pick_gnt_s)
   );

   // video overrides the picker; nothing is granted while in reset
   always_comb begin
      if (!reset_n) begin
         gnt_s = {NUM_REQ{1'b0}};
      end else if (req[REQ_VIDEO]) begin
         gnt_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
      end else begin
         gnt_s = pick_gnt_s;
      end
   end

   // one-hot address mux and range/bypass decode
   always_comb begin
      gaddr_s = {ADDR_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         gaddr_s = gaddr_s | (addr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[i]}});
      end
      any_gnt_s    = |gnt_s;
      oob_s        = any_gnt_s && (gaddr_s > LAST_A);
      ram_we_s     = reset_n && wr_req && (wr_addr <= LAST_A);
      bypass_hit_s = any_gnt_s && !oob_s && ram_we_s && (wr_addr == gaddr_s);
   end

   assign gnt               = gnt_s;
   assign ram_read_address  = (any_gnt_s && !oob_s) ? gaddr_s : BLANK_A;
   assign ram_we            = ram_we_s;
   assign ram_write_address = wr_addr;
   assign ram_data_in       = wr_data;

   // read pipeline: RAM answers one cycle after the grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_r      <= {NUM_REQ{1'b0}};
         oob_r         <= 1'b0;
         bypass_r      <= 1'b0;
         bypass_data_r <= {DATA_W{1'b0}};
      end else begin
         rvalid_r      <= gnt_s;
         oob_r         <= oob_s;
         bypass_r      <= bypass_hit_s;
         bypass_data_r <= wr_data;
      end
   end

   // RAM is read-before-write, so a colliding write must be forwarded
   always_comb begin
      if (rvalid_r == {NUM_REQ{1'b0}}) begin
         rdata_s = {DATA_W{1'b0}};
      end else if (bypass_r) begin
         rdata_s = bypass_data_r;
      end else begin
         rdata_s = ram_data_out;
      end
   end

   assign rvalid  = rvalid_r;
   assign rdata   = rdata_s;
   assign oob_err = oob_r;

   // saturating wait counters; clear on grant or withdrawn request
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_s[i] || !req[i]) begin
            wait_nxt_s[i] = {CNT_W{1'b0}};
         end else if (wait_r[i] != LIMIT_C) begin
            wait_nxt_s[i] = wait_r[i] + CNT_W'(1);
         end else begin
            wait_nxt_s[i] = wait_r[i];
         end
      end
   end

   // wait counters and starvation status
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_r[i] <= {CNT_W{1'b0}};
         end
         starve_r <= {NUM_REQ{1'b0}};
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_r[i]   <= wait_nxt_s[i];
            starve_r[i] <= (wait_nxt_s[i] == LIMIT_C);
         end
      end
   end

   assign starve = starve_r;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Scoreboard bench for sprite_ram_arbiter with a behavioural sprite RAM.
module tb_sprite_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  req;
   logic [32:0] addr;
   logic [2:0]  gnt, rvalid, starve;
   logic [7:0]  rdata;
   logic        oob_err;
   logic        wr_req;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;
   logic [10:0] ram_read_address, ram_write_address;
   logic [7:0]  ram_data_in, ram_data_out;
   logic        ram_we;

   typedef struct {
      logic [2:0] oh;
      logic [7:0] data;
      logic       oob;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   m_ptr = 1;
   int   m_wait[3];

   bit [7:0] ram_mem [0:2047];
   bit       ram_wr  [0:2047];
   bit [7:0] mdl_mem [0:2047];
   bit       mdl_wr  [0:2047];
   logic [7:0] ram_q;

   sprite_ram_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
      .rvalid(rvalid), .rdata(rdata), .oob_err(oob_err), .starve(starve),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
      .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 7 + 3) ^ 32'h5C);
   endfunction

   // behavioural sprite RAM: registered read, read-before-write
   always @(posedge clk) begin
      ram_q <= ram_wr[ram_read_address] ? ram_mem[ram_read_address] : init_val(int'(ram_read_address));
      if (ram_we) begin
         ram_mem[ram_write_address] <= ram_data_in;
         ram_wr[ram_write_address]  <= 1'b1;
      end
   end
   assign ram_data_out = ram_q;

   function automatic logic [7:0] mread(input int a);
      return mdl_wr[a] ? mdl_mem[a] : init_val(a);
   endfunction

   function automatic logic [2:0] model_gnt(input logic [2:0] r, input int p);
      logic [2:0] g;
      g = 3'b000;
      if (r[0]) g = 3'b001;
`ifdef SPRITE_ARB_RR_EN
      else if (p == 1) g = r[1] ? 3'b010 : (r[2] ? 3'b100 : 3'b000);
      else g = r[2] ? 3'b100 : (r[1] ? 3'b010 : 3'b000);
`else
      else if (r[1]) g = 3'b010;
      else if (r[2]) g = 3'b100;
`endif
      return g;
   endfunction

   task automatic set_addr(input int i, input int a);
      addr[i*11 +: 11] = 11'(a);
   endtask

   task automatic model_reset();
      sb.delete();
      m_ptr = 1;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
   endtask

   // one clock of stimulus: predict, push, advance, pop and compare
   task automatic tick();
      logic [2:0]  eg;
      logic [10:0] ga, era;
      logic        eoob, ewe;
      logic [2:0]  est;
      exp_t        e;
      #1;
      eg = model_gnt(req, m_ptr);
      ga = 11'd0;
      for (int i = 0; i < 3; i++) if (eg[i]) ga = addr[i*11 +: 11];
      eoob = (eg != 3'b000) && (ga > 11'd1706);
      era  = ((eg != 3'b000) && !eoob) ? ga : 11'd1706;
      ewe  = wr_req && (wr_addr <= 11'd1706);
      vectors++;
      if (gnt !== eg) begin miscompares++; $display("FAIL gnt: got %b expected %b", gnt, eg); end
      vectors++;
      if (ram_read_address !== era) begin miscompares++; $display("FAIL ram_read_address: got %0d expected %0d", ram_read_address, era); end
      vectors++;
      if (ram_we !== ewe) begin miscompares++; $display("FAIL ram_we: got %b expected %b", ram_we, ewe); end
      if (eg != 3'b000) begin
         e.oh  = eg;
         e.oob = eoob;
         if (eoob) e.data = mread(1706);
         else if (ewe && (wr_addr == ga)) e.data = wr_data;
         else e.data = mread(int'(ga));
         sb.push_back(e);
      end
      @(posedge clk);
      if (ewe) begin mdl_mem[wr_addr] = wr_data; mdl_wr[wr_addr] = 1'b1; end
      if (eg == 3'b010) m_ptr = 2;
      else if (eg == 3'b100) m_ptr = 1;
      for (int i = 0; i < 3; i++) begin
         if (req[i] && !eg[i]) begin
            if (m_wait[i] < 15) m_wait[i]++;
         end else m_wait[i] = 0;
      end
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if (rvalid !== e.oh || rdata !== e.data || oob_err !== e.oob) begin
            miscompares++;
            $display("FAIL read: got rvalid=%b rdata=%h oob=%b expected rvalid=%b rdata=%h oob=%b",
                     rvalid, rdata, oob_err, e.oh, e.data, e.oob);
         end
      end else begin
         vectors++;
         if (rvalid !== 3'b000 || oob_err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_read: got rvalid=%b oob=%b expected 000/0", rvalid, oob_err);
         end
      end
      for (int i = 0; i < 3; i++) est[i] = (m_wait[i] == 15);
      vectors++;
      if (starve !== est) begin miscompares++; $display("FAIL starve: got %b expected %b", starve, est); end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req = 3'b000; wr_req = 1'b0; wr_addr = 11'd0; wr_data = 8'h00; addr = 33'd0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      req = 3'b111; wr_req = 1'b1; wr_addr = 11'd5; wr_data = 8'h11;
      #3;
      vectors++;
      if (gnt !== 3'b000 || ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_gnt_we: got gnt=%b we=%b expected 000/0", gnt, ram_we); end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (rvalid !== 3'b000 || rdata !== 8'h00 || oob_err !== 1'b0 || starve !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_outputs: got rvalid=%b rdata=%h oob=%b starve=%b expected all zero", rvalid, rdata, oob_err, starve);
      end
      @(negedge clk);
      model_reset();
      idle_inputs();
      reset_n = 1'b1;
      req = 3'b010; set_addr(1, 50);
      tick();
      vectors++;
      if (rvalid !== 3'b010) begin miscompares++; $display("FAIL first_grant: got rvalid=%b expected 010", rvalid); end
      idle_inputs();
   endtask

   task automatic test_video_priority();
      req = 3'b011; set_addr(0, 100); set_addr(1, 200);
      tick();
      vectors++;
      if (rvalid !== 3'b001 || rdata !== mread(100)) begin
         miscompares++; $display("FAIL video_first: got %b/%h expected 001/%h", rvalid, rdata, mread(100));
      end
      req = 3'b010;
      #1;
      vectors++;
      if (gnt !== 3'b010) begin miscompares++; $display("FAIL video_then_req1: got %b expected 010", gnt); end
      tick();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g;
      apply_reset();
      req = 3'b110; set_addr(1, 10); set_addr(2, 20);
      for (int c = 0; c < 4; c++) begin
`ifdef SPRITE_ARB_RR_EN
         exp_g = (c % 2 == 0) ? 3'b010 : 3'b100;
`else
         exp_g = 3'b010;
`endif
         #1;
         vectors++;
         if (gnt !== exp_g) begin miscompares++; $display("FAIL rr_seq%0d: got %b expected %b", c, gnt, exp_g); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_oob();
      req = 3'b010; set_addr(1, 1800);
      #1;
      vectors++;
      if (ram_read_address !== 11'd1706) begin miscompares++; $display("FAIL oob_addr: got %0d expected 1706", ram_read_address); end
      tick();
      vectors++;
      if (rvalid !== 3'b010 || oob_err !== 1'b1 || rdata !== mread(1706)) begin
         miscompares++; $display("FAIL oob_read: got %b/%b/%h expected 010/1/%h", rvalid, oob_err, rdata, mread(1706));
      end
      set_addr(1, 1706);
      tick();
      vectors++;
      if (oob_err !== 1'b0) begin miscompares++; $display("FAIL oob_last: got %b expected 0", oob_err); end
      set_addr(1, 1707);
      tick();
      vectors++;
      if (oob_err !== 1'b1) begin miscompares++; $display("FAIL oob_first: got %b expected 1", oob_err); end
      idle_inputs();
   endtask

   task automatic test_bypass();
      wr_req = 1'b1; wr_addr = 11'd300; wr_data = 8'h5A;
      req = 3'b010; set_addr(1, 300);
      tick();
      vectors++;
      if (rdata !== 8'h5A) begin miscompares++; $display("FAIL bypass: got %h expected 5a", rdata); end
      wr_req = 1'b0;
      tick();
      vectors++;
      if (rdata !== 8'h5A) begin miscompares++; $display("FAIL written: got %h expected 5a", rdata); end
      req = 3'b000; wr_req = 1'b1; wr_addr = 11'd1750; wr_data = 8'hC3;
      #1;
      vectors++;
      if (ram_we !== 1'b0) begin miscompares++; $display("FAIL wr_oob: got %b expected 0", ram_we); end
      tick();
      idle_inputs();
   endtask

   task automatic test_starve();
      req = 3'b011; set_addr(0, 1); set_addr(1, 2);
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 14) begin
            vectors++;
            if (starve[1] !== 1'b0) begin miscompares++; $display("FAIL starve_c14: got %b expected 0", starve[1]); end
         end
         if (c == 15 || c == 16) begin
            vectors++;
            if (starve[1] !== 1'b1) begin miscompares++; $display("FAIL starve_c%0d: got %b expected 1", c, starve[1]); end
         end
      end
      req = 3'b010;
      tick();
      vectors++;
      if (starve[1] !== 1'b0 || rvalid !== 3'b010) begin
         miscompares++; $display("FAIL starve_clear: got %b/%b expected 0/010", starve[1], rvalid);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 24; c++) begin
         req = 3'($urandom_range(0, 7));
         for (int i = 0; i < 3; i++) set_addr(i, (c % 3 == 0) ? 300 : int'($urandom_range(0, 1799)));
         wr_req  = 1'($urandom_range(0, 1));
         wr_addr = (c % 3 == 0) ? 11'd300 : 11'($urandom_range(0, 1799));
         wr_data = 8'($urandom_range(0, 255));
         tick();
      end
      idle_inputs();
      tick();
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_reset_inflight();
      req = 3'b010; set_addr(1, 40);
      #1;
      vectors++;
      if (gnt !== 3'b010) begin miscompares++; $display("FAIL inflight_gnt: got %b expected 010", gnt); end
      #1 reset_n = 1'b0;
      #1;
      vectors++;
      if (gnt !== 3'b000) begin miscompares++; $display("FAIL inflight_gnt_rst: got %b expected 000", gnt); end
      @(posedge clk);
      #1;
      vectors++;
      if (rvalid !== 3'b000 || rdata !== 8'h00 || oob_err !== 1'b0 || starve !== 3'b000) begin
         miscompares++; $display("FAIL inflight_rst: got %b/%h/%b/%b expected zeros", rvalid, rdata, oob_err, starve);
      end
      model_reset();
      @(negedge clk);
      idle_inputs();
      reset_n = 1'b1;
      tick();
      tick();
      vectors++;
      if (rvalid !== 3'b000) begin miscompares++; $display("FAIL inflight_release: got %b expected 000", rvalid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
      idle_inputs();
      reset_n = 1'b0;
      test_reset();
      test_video_priority();
      test_round_robin();
      test_oob();
      test_bypass();
      test_starve();
      test_back_to_back();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
